// File: rtl/seven_scanner.sv
// Multiplexed driver for a common-anode 8-digit seven-segment display.
// Optional per-frame brightness: define SEVEN_SCANNER_BRIGHTNESS_EN.
module seven_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       enable,
`ifdef SEVEN_SCANNER_BRIGHTNESS_EN
    input  logic [3:0]                 brightness,
`endif
    input  logic [NUM_DIGITS-1:0][7:0] segments_in,
    output logic [NUM_DIGITS-1:0]      an,
    output logic [7:0]                 ca,
    output logic                       frame_start
);

    localparam int MAXC = (BLANK_CYCLES > DIGIT_CYCLES) ? BLANK_CYCLES : DIGIT_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t                       state_q, state_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][7:0]   snap_q, snap_d;
    logic [NUM_DIGITS-1:0]        an_q, an_d;
    logic [7:0]                   ca_q, ca_d;
    logic                         fs_q, fs_d;
    logic                         lit;
`ifdef SEVEN_SCANNER_BRIGHTNESS_EN
    logic [3:0]                   bri_q, bri_d;
    logic [31:0]                  on_cycles;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        fs_d    = 1'b0;
`ifdef SEVEN_SCANNER_BRIGHTNESS_EN
        bri_d   = bri_q;
`endif
        if (!enable) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                    snap_d  = segments_in;
                    fs_d    = 1'b1;
`ifdef SEVEN_SCANNER_BRIGHTNESS_EN
                    bri_d   = brightness;
`endif
                end
                S_BLANK: begin
                    if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                        state_d = S_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == CW'(DIGIT_CYCLES - 1)) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                        if (idx_q == IW'(NUM_DIGITS - 1)) begin
                            // Frame wrap: take a fresh, tear-free snapshot.
                            idx_d  = '0;
                            snap_d = segments_in;
                            fs_d   = 1'b1;
`ifdef SEVEN_SCANNER_BRIGHTNESS_EN
                            bri_d  = brightness;
`endif
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with it.
    always_comb begin
`ifdef SEVEN_SCANNER_BRIGHTNESS_EN
        on_cycles = (32'(DIGIT_CYCLES) * (32'(bri_d) + 32'd1)) >> 4;
        lit       = (state_d == S_DRIVE) && (32'(cnt_d) < on_cycles);
`else
        lit       = (state_d == S_DRIVE);
`endif
        an_d = '1;
        ca_d = 8'hFF;
        if (lit) begin
            an_d[idx_d] = 1'b0;
            ca_d        = snap_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            snap_q  <= {NUM_DIGITS{8'hFF}};
            an_q    <= '1;
            ca_q    <= 8'hFF;
            fs_q    <= 1'b0;
`ifdef SEVEN_SCANNER_BRIGHTNESS_EN
            bri_q   <= 4'hF;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            ca_q    <= ca_d;
            fs_q    <= fs_d;
`ifdef SEVEN_SCANNER_BRIGHTNESS_EN
            bri_q   <= bri_d;
`endif
        end
    end

    assign an          = an_q;
    assign ca          = ca_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_scanner.sv
// Bench for seven_scanner: frame-timeline model plus directed literal checks.
module tb_seven_scanner;

    localparam int ND = 8;
`ifdef SEVEN_SCANNER_BRIGHTNESS_EN
    localparam int DC = 16;
`else
    localparam int DC = 4;
`endif
    localparam int BC    = 2;
    localparam int SLOT  = BC + DC;
    localparam int FRAME = ND * SLOT;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              enable = 1'b0;
    logic [3:0]        bri = 4'd15;
    logic [ND-1:0][7:0] segs;
    logic [ND-1:0]     an;
    logic [7:0]        ca;
    logic              frame_start;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    seven_scanner #(
        .NUM_DIGITS(ND),
        .DIGIT_CYCLES(DC),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .enable(enable),
`ifdef SEVEN_SCANNER_BRIGHTNESS_EN
        .brightness(bri),
`endif
        .segments_in(segs),
        .an(an),
        .ca(ca),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Model: time elapsed within the current frame, plus the frame's snapshot.
    bit         m_act = 1'b0;
    int         m_t = 0;
    logic [7:0] m_snap [ND];
    int         m_bri = 15;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_act <= 1'b0;
            m_t   <= 0;
        end else if (!enable) begin
            m_act <= 1'b0;
            m_t   <= 0;
        end else if (!m_act || m_t == FRAME - 1) begin
            m_act <= 1'b1;
            m_t   <= 0;
            m_bri <= int'(bri);
            for (int i = 0; i < ND; i++) m_snap[i] <= segs[i];
        end else begin
            m_t <= m_t + 1;
        end
    end

    int            blank_run = 0;
    bit            seen_lit = 1'b0;
    logic [ND-1:0] last_an = '1;

    always @(negedge clk) begin
        logic [ND-1:0] an_e;
        logic [7:0]    ca_e;
        logic          fs_e;
        int slot, off, on;
        an_e = '1;
        ca_e = 8'hFF;
        fs_e = 1'b0;
        if (m_act) begin
            slot = m_t / SLOT;
            off  = m_t % SLOT;
            on   = (DC * (m_bri + 1)) / 16;
            fs_e = (m_t == 0);
            if (off >= BC && (off - BC) < on) begin
                an_e = ~(ND'(1) << slot);
                ca_e = m_snap[slot];
            end
        end
        chk("an", 32'(an), 32'(an_e));
        chk("ca", 32'(ca), 32'(ca_e));
        chk("frame_start", 32'(frame_start), 32'(fs_e));
        chk("one_low", 32'($countones(~an) <= 1), 32'd1);
        if (an == '1) chk("blank_ca", 32'(ca), 32'hFF);
`ifndef SEVEN_SCANNER_BRIGHTNESS_EN
        if (an != '1 && an != last_an && seen_lit)
            chk("dead_time", 32'(blank_run), 32'(BC));
`endif
        if (!m_act || !resetn) begin
            seen_lit  = 1'b0;
            blank_run = 0;
        end else if (an == '1) begin
            blank_run++;
        end else begin
            seen_lit  = 1'b1;
            blank_run = 0;
            last_an   = an;
        end
    end

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic go(input int k);
        while (cyc < k) step();
    endtask

    task automatic reset_start();
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        enable = 1'b1;
        cyc = -1;
    endtask

    initial begin
        for (int i = 0; i < ND; i++) segs[i] = 8'hC0 + 8'(i);
`ifdef SEVEN_SCANNER_BRIGHTNESS_EN
        bri = 4'd3;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_ca", 32'(ca), 32'hFF);
        chk("rst_fs", 32'(frame_start), 32'd0);
        resetn = 1'b1;
        enable = 1'b1;
        cyc = -1;
`ifdef SEVEN_SCANNER_BRIGHTNESS_EN
        go(0);  chk("b_fs0", 32'(frame_start), 32'd1);
        go(2);  chk("b_an2", 32'(an), 32'hFE);
        go(5);  chk("b_an5", 32'(an), 32'hFE);
        go(6);  chk("b_an6", 32'(an), 32'hFF);
        go(10); bri = 4'd15;
        go(17); chk("b_an17", 32'(an), 32'hFF);
        go(20); chk("b_an20", 32'(an), 32'hFD);
        go(23); chk("b_ca23", 32'(ca), 32'hC1);
        go(24); chk("b_an24", 32'(an), 32'hFF);
        go(144); chk("b_fs144", 32'(frame_start), 32'd1);
        go(146); chk("b_an146", 32'(an), 32'hFE);
        go(161); chk("b_an161", 32'(an), 32'hFE);
        go(162); chk("b_an162", 32'(an), 32'hFF);
        go(3 * FRAME);
`else
        go(0);  chk("fs0", 32'(frame_start), 32'd1);
        chk("an0", 32'(an), 32'hFF);
        for (int k = 2; k <= 5; k++) begin
            go(k);
            chk("d0_an", 32'(an), 32'hFE);
            chk("d0_ca", 32'(ca), 32'hC0);
        end
        for (int k = 8; k <= 11; k++) begin
            go(k);
            chk("d1_an", 32'(an), 32'hFD);
            chk("d1_ca", 32'(ca), 32'hC1);
            if (k == 10) segs[3] = 8'h99;
        end
        for (int k = 20; k <= 23; k++) begin
            go(k);
            chk("d3_old", 32'(ca), 32'hC3);
        end
        go(48); chk("fs48", 32'(frame_start), 32'd1);
        for (int k = 68; k <= 71; k++) begin
            go(k);
            chk("d3_an", 32'(an), 32'hF7);
            chk("d3_new", 32'(ca), 32'h99);
        end
        go(96); chk("fs96", 32'(frame_start), 32'd1);
        go(3 * FRAME);

        segs[3] = 8'hC3;
        reset_start();
        go(15); chk("en_d2", 32'(an), 32'hFB);
        enable = 1'b0;
        go(16); chk("dis_an", 32'(an), 32'hFF);
        chk("dis_ca", 32'(ca), 32'hFF);
        go(29); enable = 1'b1;
        go(30); chk("re_fs", 32'(frame_start), 32'd1);
        go(32); chk("re_an", 32'(an), 32'hFE);
        chk("re_ca", 32'(ca), 32'hC0);

        reset_start();
        go(33); chk("pre_rst_an", 32'(an), 32'hDF);
        #2 resetn = 1'b0;
        #1 chk("async_an", 32'(an), 32'hFF);
        chk("async_ca", 32'(ca), 32'hFF);
        @(negedge clk);
        resetn = 1'b1;
        cyc = -1;
        go(0); chk("rs_fs", 32'(frame_start), 32'd1);
        go(2); chk("rs_an", 32'(an), 32'hFE);
        go(FRAME + 4);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_scanner.md
Name: seven_scanner

Overview:
- Time-multiplexing driver for the board's common-anode 8-digit seven-segment display.
- Consumes the per-digit active-low cathode bus produced by the display/demo blocks: segments[8], 8 bits each, bit 7 = DP.
- Drives the physical shared cathode lines and per-digit anode enables, with dead-time blanking between digits to prevent ghosting.
- Snapshots the whole segment bus once per frame so a frame never tears mid-scan.

Parameters:
- NUM_DIGITS, 8: number of digits scanned. Index width is $clog2(NUM_DIGITS).
- DIGIT_CYCLES, 100000: clk cycles each digit is driven. Must be ≥1.
- BLANK_CYCLES, 1000: clk cycles of all-off dead time before each digit. Must be ≥1.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset: asynchronous, active-low.
- enable  input  1  scan enable. While low, the display is blank.
- segments_in  input  8 x [NUM_DIGITS]  per-digit cathodes, active-low, bit 7 = DP.
- an  output  NUM_DIGITS  digit anode enables, active-low.
- ca  output  8  shared cathodes, active-low, bit 7 = DP.
- frame_start  output  1  one-cycle pulse in the first cycle of each frame.

Behaviour:
- Reset values (asynchronous, take effect immediately, including mid-scan):
  - an = all 1s; ca = 8'hFF; frame_start = 0.
  - State IDLE; digit index = 0; cycle counter = 0; snapshot = all 8'hFF.
- States:
  - IDLE: blank.
  - BLANK(idx): an all 1s, ca = 8'hFF.
  - DRIVE(idx): an[idx] = 0, all other an bits = 1; ca = snap[idx].
- All outputs are registered and are decoded from the next state, so an/ca/frame_start correspond to the state held in that same cycle. No extra output latency.
- IDLE -> BLANK(0), when enable = 1 at a clock edge:
  - counter = 0.
  - snap <= segments_in (all digits).
  - frame_start = 1 for that one cycle.
- BLANK(idx) -> DRIVE(idx) after BLANK_CYCLES cycles in BLANK. Counter resets to 0.
- DRIVE(idx) -> next slot after DIGIT_CYCLES cycles in DRIVE:
  - idx < NUM_DIGITS-1: go to BLANK(idx+1).
  - idx = NUM_DIGITS-1: wrap to BLANK(0), re-snapshot, and pulse frame_start exactly as on IDLE exit.
- Timing:
  - Slot period = BLANK_CYCLES + DIGIT_CYCLES.
  - Frame period = NUM_DIGITS x slot period.
  - frame_start is periodic at the frame period while enable stays high.
- Scan order is ascending: an[i] always pairs with snap[i].
- segments_in changes mid-frame have no effect until the next frame snapshot.
- enable = 0 in any state: the next edge goes to IDLE with outputs blank; counter and idx are cleared. The frame is abandoned, not resumed. Re-enabling starts a fresh frame from digit 0 with a new snapshot.
- The counter never exceeds max(BLANK_CYCLES, DIGIT_CYCLES)-1. Counter width = $clog2(max(BLANK_CYCLES, DIGIT_CYCLES)).
- an never has more than one bit low. ca is never non-FF while an is all 1s.

Optional Feature:
- Macro: SEVEN_SCANNER_BRIGHTNESS_EN.
- With the macro defined:
  - Adds port brightness, input, 4 bits.
  - brightness is sampled into the snapshot alongside segments_in at each frame start.
  - on_cycles = (DIGIT_CYCLES * (brightness+1)) >> 4.
  - In DRIVE, the digit is lit (an[idx] = 0, ca = snap[idx]) only while counter < on_cycles. For the remainder of DRIVE, outputs are blank.
  - Slot timing is unchanged. brightness = 15 gives full on-time; on_cycles = 0 gives a dark digit.
- Without the macro: the port is absent, and the digit is lit for the whole DRIVE period.

Test Plan:
All scenarios use NUM_DIGITS=8, DIGIT_CYCLES=4, BLANK_CYCLES=2 (slot = 6, frame = 48).
- Reset then enable=1, segments_in[i] = 8'hC0 + i:
  - Cycle 0: frame_start = 1, an = FF.
  - Cycles 2-5: an = 8'hFE, ca = C0.
  - Cycles 8-11: an = 8'hFD, ca = C1.
  - frame_start repeats at cycles 48 and 96.
- Change segments_in[3] to 8'h99 at cycle 10:
  - Cycles 20-23 (digit 3) still show C3.
  - The next frame's digit 3 (cycles 68-71) shows 99.
- Drop enable at cycle 15 (during DRIVE(2)):
  - From the next cycle: an = FF, ca = FF.
  - Re-enable at cycle 30: frame_start = 1, digit 0 is driven again 2 cycles later.
- Assert resetn low mid-DRIVE(5):
  - an = FF and ca = FF immediately, without waiting for a clock edge.
  - After release with enable=1: scan restarts at digit 0.
- Continuous check over 3 frames:
  - an has at most one zero bit.
  - Every digit change is preceded by exactly 2 all-blank cycles.
  - ca = FF whenever an = FF.
- With SEVEN_SCANNER_BRIGHTNESS_EN, DIGIT_CYCLES=16:
  - brightness = 3: each digit lit 4 cycles, then 12 blank.
  - brightness = 15: lit 16 cycles.
  - brightness changed mid-frame takes effect at the next frame_start.
